// File: rtl/forwarding_source_pkg.sv
// cpu_fwd_pkg: shared register encodings, FSM states and select helpers for the forwarding source.
package cpu_fwd_pkg;
   localparam logic [3:0] REG0_LD = 4'd8;
   localparam logic [3:0] REG1_LD = 4'd4;
   localparam logic [3:0] REG2_LD = 4'd2;
   localparam logic [3:0] REG3_LD = 4'd1;
   localparam logic [2:0] SEL_R0 = 3'd0;
   localparam logic [2:0] SEL_R1 = 3'd1;
   localparam logic [2:0] SEL_R2 = 3'd2;
   localparam logic [2:0] SEL_R3 = 3'd3;
   typedef enum logic {IDLE, STALL} fsm_state_t;
   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction
   // codes 4..7 are non-register sources and map to no destination
   function automatic logic [3:0] sel_to_onehot(input logic [2:0] s);
      return s[2] ? 4'd0 : REG0_LD >> s[1:0];
   endfunction
endpackage

// File: rtl/forwarding_source_if.sv
// forwarding_source_if: writeback, interlock and history signals of the forwarding source.
interface forwarding_source_if #(parameter int DATA_W = 16);
   logic              WB_VALID;
   logic [3:0]        WB_LD;
   logic [DATA_W-1:0] WB_DATA;
   logic              STALL_IN;
   logic              FLUSH;
   logic              MEM_LOAD_EX;
   logic [3:0]        LD_EX;
   logic [5:0]        SEL_ID;
   logic [DATA_W-1:0] BUS;
   logic [3:0]        LD_reg;
   logic [DATA_W-1:0] BUS_past;
   logic [3:0]        LD_reg_past;
   logic              STALL_REQ;
   modport slave (
      input  WB_VALID, WB_LD, WB_DATA, STALL_IN, FLUSH, MEM_LOAD_EX, LD_EX, SEL_ID,
      output BUS, LD_reg, BUS_past, LD_reg_past, STALL_REQ
   );
   modport master (
      output WB_VALID, WB_LD, WB_DATA, STALL_IN, FLUSH, MEM_LOAD_EX, LD_EX, SEL_ID,
      input  BUS, LD_reg, BUS_past, LD_reg_past, STALL_REQ
   );
endinterface

// File: rtl/forwarding_source_loaduse_fsm.sv
// loaduse_fsm: load-use hazard compare and stall FSM holding STALL_REQ for LOAD_LAT cycles.
module loaduse_fsm
   import cpu_fwd_pkg::*;
#(
   parameter int LOAD_LAT = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       STALL_IN,
   input  logic       FLUSH,
   input  logic       MEM_LOAD_EX,
   input  logic [3:0] LD_EX,
   input  logic [5:0] SEL_ID,
   output logic       STALL_REQ
);
   fsm_state_t state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic       hazard;
   logic [3:0] src;
   assign src = sel_to_onehot(SEL_ID[5:3]) | sel_to_onehot(SEL_ID[2:0]);
   assign hazard = MEM_LOAD_EX & is_onehot(LD_EX) & (|(src & LD_EX));
   assign STALL_REQ = ~FLUSH & ((state == STALL) | hazard);
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end
   // the hazard cycle itself is the first stall cycle, so STALL covers LOAD_LAT-1 more
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (FLUSH) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (!STALL_IN && state == IDLE && hazard && LOAD_LAT > 1) begin
         state_nx = STALL;
         cnt_nx   = 3'(LOAD_LAT - 1);
      end else if (!STALL_IN && state == STALL) begin
         cnt_nx = cnt - 3'd1;
         if (cnt == 3'd1) state_nx = IDLE;
      end
   end
endmodule

// File: rtl/forwarding_source.sv
// forwarding_source: two-deep writeback history for operand forwarding plus load-use interlock.
// The interlock is built only when FWD_LOADUSE_EN is defined; otherwise STALL_REQ is tied low.
module forwarding_source
   import cpu_fwd_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int LOAD_LAT = 1
) (
   input logic CLK,
   input logic RST,
   forwarding_source_if.slave fwd
);
   logic wr;
   assign wr = fwd.WB_VALID & is_onehot(fwd.WB_LD);
   // history is committed state, so FLUSH deliberately leaves it alone
   always_ff @(posedge CLK) begin
      if (RST) begin
         fwd.BUS         <= '0;
         fwd.LD_reg      <= '0;
         fwd.BUS_past    <= '0;
         fwd.LD_reg_past <= '0;
      end else if (!fwd.STALL_IN) begin
         fwd.BUS         <= wr ? fwd.WB_DATA : '0;
         fwd.LD_reg      <= wr ? fwd.WB_LD : '0;
         fwd.BUS_past    <= fwd.BUS;
         fwd.LD_reg_past <= fwd.LD_reg;
      end
   end
`ifdef FWD_LOADUSE_EN
   loaduse_fsm #(.LOAD_LAT(LOAD_LAT)) u_fsm (
      .CLK         (CLK),
      .RST         (RST),
      .STALL_IN    (fwd.STALL_IN),
      .FLUSH       (fwd.FLUSH),
      .MEM_LOAD_EX (fwd.MEM_LOAD_EX),
      .LD_EX       (fwd.LD_EX),
      .SEL_ID      (fwd.SEL_ID),
      .STALL_REQ   (fwd.STALL_REQ)
   );
`else
   logic unused_ok;
   assign unused_ok = ^{fwd.FLUSH, fwd.MEM_LOAD_EX, fwd.LD_EX, fwd.SEL_ID, 3'(LOAD_LAT)};
   assign fwd.STALL_REQ = 1'b0;
`endif
endmodule

// File: tb/tb_forwarding_source.sv
// tb_forwarding_source: directed and random checks of two instances (LOAD_LAT=1 and 3) against a reference model.
module tb_forwarding_source;
   localparam int DW = 16;
`ifdef FWD_LOADUSE_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, wb_valid, stall_in, flush, mem_load_ex;
   logic [3:0] wb_ld, ld_ex;
   logic [DW-1:0] wb_data;
   logic [5:0] sel_id;
   forwarding_source_if #(.DATA_W(DW)) if1 ();
   forwarding_source_if #(.DATA_W(DW)) if3 ();
   assign if1.WB_VALID = wb_valid;
   assign if1.WB_LD = wb_ld;
   assign if1.WB_DATA = wb_data;
   assign if1.STALL_IN = stall_in;
   assign if1.FLUSH = flush;
   assign if1.MEM_LOAD_EX = mem_load_ex;
   assign if1.LD_EX = ld_ex;
   assign if1.SEL_ID = sel_id;
   assign if3.WB_VALID = wb_valid;
   assign if3.WB_LD = wb_ld;
   assign if3.WB_DATA = wb_data;
   assign if3.STALL_IN = stall_in;
   assign if3.FLUSH = flush;
   assign if3.MEM_LOAD_EX = mem_load_ex;
   assign if3.LD_EX = ld_ex;
   assign if3.SEL_ID = sel_id;
   forwarding_source #(.DATA_W(DW), .LOAD_LAT(1)) dut1 (.CLK(clk), .RST(rst), .fwd(if1.slave));
   forwarding_source #(.DATA_W(DW), .LOAD_LAT(3)) dut3 (.CLK(clk), .RST(rst), .fwd(if3.slave));
   int checks = 0;
   int errors = 0;
   logic [DW-1:0] m_data [2];
   logic [3:0] m_ld [2];
   int owe1, owe3;
   logic r1_s, r3_s;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit ref_hazard();
      int s [2];
      if (!mem_load_ex || $countones(ld_ex) != 1) return 0;
      s[0] = int'(sel_id[5:3]);
      s[1] = int'(sel_id[2:0]);
      foreach (s[i]) if (s[i] < 4 && ld_ex[3 - s[i]]) return 1;
      return 0;
   endfunction
   function automatic logic exp_req(input int owe);
      if (!EN || flush) return 1'b0;
      return (owe > 0) ? 1'b1 : logic'(ref_hazard());
   endfunction
   // owed cycles remaining after the current one; a hazard owes LOAD_LAT-1 more
   function automatic int next_owe(input int owe, input int lat);
      if (rst || flush) return 0;
      if (stall_in) return owe;
      if (owe > 0) return owe - 1;
      return ref_hazard() ? lat - 1 : 0;
   endfunction
   task automatic cyc(input logic r, input logic wv, input logic [3:0] wld, input logic [DW-1:0] wd,
                      input logic sin, input logic fl, input logic ml, input logic [3:0] lde, input logic [5:0] sel);
      rst = r; wb_valid = wv; wb_ld = wld; wb_data = wd;
      stall_in = sin; flush = fl; mem_load_ex = ml; ld_ex = lde; sel_id = sel;
      @(negedge clk);
      chk("bus1", 32'(if1.BUS), 32'(m_data[0]));
      chk("ld1", 32'(if1.LD_reg), 32'(m_ld[0]));
      chk("bus_past1", 32'(if1.BUS_past), 32'(m_data[1]));
      chk("ld_past1", 32'(if1.LD_reg_past), 32'(m_ld[1]));
      chk("bus3", 32'(if3.BUS), 32'(m_data[0]));
      chk("ld_past3", 32'(if3.LD_reg_past), 32'(m_ld[1]));
      chk("req1", 32'(if1.STALL_REQ), 32'(exp_req(owe1)));
      chk("req3", 32'(if3.STALL_REQ), 32'(exp_req(owe3)));
      r1_s = if1.STALL_REQ;
      r3_s = if3.STALL_REQ;
      @(posedge clk);
      if (rst) begin
         m_data = '{default: '0};
         m_ld = '{default: '0};
      end else if (!stall_in) begin
         m_data[1] = m_data[0];
         m_ld[1] = m_ld[0];
         m_data[0] = (wb_valid && $countones(wb_ld) == 1) ? wb_data : '0;
         m_ld[0] = (wb_valid && $countones(wb_ld) == 1) ? wb_ld : '0;
      end
      owe1 = next_owe(owe1, 1);
      owe3 = next_owe(owe3, 3);
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'o77);
   endtask
   initial begin
      rst = 1; wb_valid = 0; wb_ld = 0; wb_data = 0; stall_in = 0; flush = 0;
      mem_load_ex = 0; ld_ex = 0; sel_id = 0;
      repeat (2) @(posedge clk);
      #1;
      m_data = '{default: '0};
      m_ld = '{default: '0};
      owe1 = 0;
      owe3 = 0;
      idle(1);
      chk("rst_ld", 32'(if1.LD_reg), 32'd0);
      chk("rst_req", 32'(r3_s), 32'd0);
      cyc(0, 1, 4'd4, 16'h1234, 0, 0, 0, 0, 6'o77);
      chk("cap_bus", 32'(if1.BUS), 32'h1234);
      chk("cap_ld", 32'(if1.LD_reg), 32'd4);
      chk("cap_ld_past", 32'(if1.LD_reg_past), 32'd0);
      idle(1);
      chk("cap_bus_past", 32'(if1.BUS_past), 32'h1234);
      chk("cap_ld_next", 32'(if1.LD_reg), 32'd0);
      cyc(0, 1, 4'd6, 16'hAAAA, 0, 0, 0, 0, 6'o77);
      chk("multi_ld", 32'(if1.LD_reg), 32'd0);
      cyc(0, 1, 4'd1, 16'hBEEF, 0, 0, 0, 0, 6'o77);
      cyc(0, 1, 4'd0, 16'h5555, 0, 0, 0, 0, 6'o77);
      chk("zero_ld", 32'(if1.LD_reg), 32'd0);
      chk("zero_past", 32'(if1.LD_reg_past), 32'd1);
      for (int i = 0; i < 3; i++) cyc(0, 1, 4'd8, 16'h7777, 1, 0, 0, 0, 6'o77);
      chk("hold_past", 32'(if1.BUS_past), 32'hBEEF);
      cyc(0, 0, 0, 0, 0, 0, 1, 4'd2, 6'b010_101);
      chk("ll1_hit", 32'(r1_s), 32'(EN));
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'o77);
      chk("ll1_after", 32'(r1_s), 32'd0);
      chk("ll3_n1", 32'(r3_s), 32'(EN));
      idle(1);
      chk("ll3_n2", 32'(r3_s), 32'(EN));
      idle(1);
      chk("ll3_n3", 32'(r3_s), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 1, 4'd2, 6'b100_111);
      chk("nonreg_sel", 32'(r1_s), 32'd0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 4'd2, 16'(i), 0, 0, 1, 4'd8, 6'b000_110);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 6'o77);
      chk("held_no_ext", 32'(r3_s), 32'd0);
      cyc(0, 1, 4'd8, 16'hC0DE, 0, 0, 1, 4'd1, 6'b011_111);
      cyc(0, 1, 4'd4, 16'hF00D, 0, 1, 0, 0, 6'o77);
      chk("flush_req", 32'(r3_s), 32'd0);
      chk("flush_hist", 32'(if3.BUS), 32'hF00D);
      idle(1);
      chk("flush_idle", 32'(r3_s), 32'd0);
      cyc(0, 0, 0, 0, 0, 0, 1, 4'd4, 6'b001_111);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 6'o77);
      chk("rst_mid_n1", 32'(r3_s), 32'(EN));
      idle(1);
      chk("rst_mid_n2", 32'(r3_s), 32'd0);
      for (int i = 0; i < 800; i++) begin
         logic [3:0] wl, le;
         wl = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd8 >> $urandom_range(0, 3);
         le = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd8 >> $urandom_range(0, 3);
         cyc($urandom_range(0, 49) == 0, 1'($urandom), wl, 16'($urandom),
             $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
             1'($urandom), le, 6'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
